// File: rtl/fib_seq_ctrl.sv
// fib_seq_ctrl: drives the ALU with two running terms, feeds the sum back,
// and emits one Fibonacci-style term per cycle on a registered stream.
module fib_seq_ctrl #(
  parameter int unsigned N_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [31:0]    f0,
  input  logic [31:0]    f1,
  input  logic [N_W-1:0] n,
  output logic [31:0]    alu_a,
  output logic [31:0]    alu_b,
  output logic [4:0]     alu_op,
  input  logic [31:0]    alu_out,
  output logic [31:0]    fib_out,
  output logic           fib_valid,
  output logic           busy,
  output logic           done,
  output logic           ovf
);

  localparam int unsigned D_W  = 32;
  localparam int unsigned OP_W = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [D_W-1:0] r_ra, w_ra_nxt;
  logic [D_W-1:0] r_rb, w_rb_nxt;
  logic           r_wa, w_wa_nxt;
  logic           r_wb, w_wb_nxt;
  logic [N_W-1:0] r_cnt, w_cnt_nxt;
  logic [D_W-1:0] r_fib_out, w_fib_out_nxt;
  logic           r_fib_valid, w_fib_valid_nxt;
  logic           r_done, w_done_nxt;
  logic           r_ovf, w_ovf_nxt;
  logic           r_busy, w_busy_nxt;

  // Next-state and next-output logic; busy lags the state by one cycle so a
  // new request is only taken once the previous run has fully drained.
  always_comb begin
    w_state_nxt     = r_state;
    w_ra_nxt        = r_ra;
    w_rb_nxt        = r_rb;
    w_wa_nxt        = r_wa;
    w_wb_nxt        = r_wb;
    w_cnt_nxt       = r_cnt;
    w_fib_out_nxt   = r_fib_out;
    w_fib_valid_nxt = 1'b0;
    w_done_nxt      = 1'b0;
    w_ovf_nxt       = r_ovf;
    w_busy_nxt      = (r_state != S_IDLE);

    case (r_state)
      S_IDLE: begin
        if (start && !r_busy) begin
          w_ra_nxt    = f0;
          w_rb_nxt    = f1;
          w_wa_nxt    = 1'b0;
          w_wb_nxt    = 1'b0;
          w_cnt_nxt   = n;
          w_ovf_nxt   = 1'b0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = (n != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        w_fib_out_nxt   = r_ra;
        w_fib_valid_nxt = 1'b1;
        w_ovf_nxt       = r_ovf | r_wa;
        w_ra_nxt        = r_rb;
        w_wa_nxt        = r_wb;
        w_rb_nxt        = alu_out;
        w_wb_nxt        = (alu_out < r_ra);
        w_cnt_nxt       = r_cnt - N_W'(1);
        if (r_cnt == N_W'(1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ra        <= '0;
      r_rb        <= '0;
      r_wa        <= 1'b0;
      r_wb        <= 1'b0;
      r_cnt       <= '0;
      r_fib_out   <= '0;
      r_fib_valid <= 1'b0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ra        <= w_ra_nxt;
      r_rb        <= w_rb_nxt;
      r_wa        <= w_wa_nxt;
      r_wb        <= w_wb_nxt;
      r_cnt       <= w_cnt_nxt;
      r_fib_out   <= w_fib_out_nxt;
      r_fib_valid <= w_fib_valid_nxt;
      r_done      <= w_done_nxt;
      r_ovf       <= w_ovf_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign alu_a     = r_ra;
  assign alu_b     = r_rb;
  assign alu_op    = OP_W'(0);
  assign fib_out   = r_fib_out;
  assign fib_valid = r_fib_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Self-checking bench for fib_seq_ctrl with a behavioural ALU and a
// term-list reference model.
module tb_fib_seq_ctrl;

  localparam int unsigned N_W = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [31:0]    f0 = '0;
  logic [31:0]    f1 = '0;
  logic [N_W-1:0] n = '0;
  logic [31:0]    alu_a;
  logic [31:0]    alu_b;
  logic [4:0]     alu_op;
  logic [31:0]    alu_out;
  logic [31:0]    fib_out;
  logic           fib_valid;
  logic           busy;
  logic           done;
  logic           ovf;

  int errors = 0;
  int checks = 0;
  logic [31:0] hold_out = '0;
  logic        ovf_hold = 1'b0;

  fib_seq_ctrl #(.N_W(N_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .f0        (f0),
    .f1        (f1),
    .n         (n),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .fib_out   (fib_out),
    .fib_valid (fib_valid),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf)
  );

  // Behavioural ALU: opcode 0 is a 32-bit wrapping add.
  assign alu_out = (alu_op == 5'd0) ? (alu_a + alu_b) : 32'hDEAD_BEEF;

  always #5 clk = ~clk;

  // One complete run: accept, n terms, done pulse, busy release.
  // poke re-asserts start (other seeds) mid-run and in the done cycle.
  task automatic test_sequence(input string name, input logic [31:0] s0,
                               input logic [31:0] s1, input int cnt,
                               input bit poke);
    logic [31:0] et[64];
    bit          ew[64];
    logic        eo;
    logic [32:0] s;
    et[0] = s0; et[1] = s1; ew[0] = 1'b0; ew[1] = 1'b0;
    for (int i = 2; i < 64; i++) begin
      s = 33'(et[i-1]) + 33'(et[i-2]);
      et[i] = s[31:0];
      ew[i] = s[32];
    end
    start = 1'b1; f0 = s0; f1 = s1; n = N_W'(cnt);
    @(posedge clk); #1;
    start = 1'b0; f0 = $urandom; f1 = $urandom; n = N_W'($urandom);
    checks++;
    if (busy !== 1'b1 || fib_valid !== 1'b0 || done !== 1'b0 || ovf !== 1'b0 ||
        fib_out !== hold_out || alu_a !== s0 || alu_b !== s1) begin
      errors++;
      $display("FAIL %s accept: busy=%b valid=%b done=%b ovf=%b out=%h a=%h b=%h expected busy=1 valid=0 done=0 ovf=0 out=%h a=%h b=%h",
               name, busy, fib_valid, done, ovf, fib_out, alu_a, alu_b, hold_out, s0, s1);
    end
    eo = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      if (poke && i == 1) begin
        start = 1'b1; f0 = 32'hFFFF_FFFF; f1 = 32'hFFFF_FFFF; n = N_W'(3);
      end
      @(posedge clk); #1;
      start = 1'b0;
      eo = eo | ew[i];
      checks++;
      if (fib_valid !== 1'b1 || fib_out !== et[i]) begin
        errors++;
        $display("FAIL %s term%0d: valid=%b out=%h expected valid=1 out=%h",
                 name, i, fib_valid, fib_out, et[i]);
      end
      checks++;
      if (ovf !== eo || done !== 1'b0 || busy !== 1'b1 || alu_op !== 5'd0 ||
          alu_a !== et[i+1] || alu_b !== et[i+2]) begin
        errors++;
        $display("FAIL %s status%0d: ovf=%b done=%b busy=%b op=%0d a=%h b=%h expected ovf=%b done=0 busy=1 op=0 a=%h b=%h",
                 name, i, ovf, done, busy, alu_op, alu_a, alu_b, eo, et[i+1], et[i+2]);
      end
      hold_out = et[i];
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || fib_valid !== 1'b0 || busy !== 1'b1 ||
        fib_out !== hold_out || ovf !== eo) begin
      errors++;
      $display("FAIL %s done_cycle: done=%b valid=%b busy=%b out=%h ovf=%b expected done=1 valid=0 busy=1 out=%h ovf=%b",
               name, done, fib_valid, busy, fib_out, ovf, hold_out, eo);
    end
    if (poke) begin
      start = 1'b1; f0 = 32'h1234_5678; f1 = 32'h1; n = N_W'(5);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || fib_valid !== 1'b0 || busy !== 1'b0 ||
        fib_out !== hold_out || ovf !== eo) begin
      errors++;
      $display("FAIL %s release: done=%b valid=%b busy=%b out=%h ovf=%b expected done=0 valid=0 busy=0 out=%h ovf=%b",
               name, done, fib_valid, busy, fib_out, ovf, hold_out, eo);
    end
    ovf_hold = eo;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (alu_a !== '0 || alu_b !== '0 || alu_op !== '0 || fib_out !== '0 ||
        fib_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset: a=%h b=%h op=%0d out=%h valid=%b busy=%b done=%b ovf=%b expected all zero",
               alu_a, alu_b, alu_op, fib_out, fib_valid, busy, done, ovf);
    end
    rst = 1'b0;
    hold_out = '0;
    ovf_hold = 1'b0;
  endtask

  task automatic test_idle_hold();
    repeat (3) begin
      f0 = $urandom; f1 = $urandom; n = N_W'($urandom);
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || fib_valid !== 1'b0 || done !== 1'b0 ||
          fib_out !== hold_out || ovf !== ovf_hold) begin
        errors++;
        $display("FAIL idle_hold: busy=%b valid=%b done=%b out=%h ovf=%b expected busy=0 valid=0 done=0 out=%h ovf=%b",
                 busy, fib_valid, done, fib_out, ovf, hold_out, ovf_hold);
      end
    end
  endtask

  task automatic test_midrun_reset();
    start = 1'b1; f0 = 32'd0; f1 = 32'd1; n = N_W'(10);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (fib_valid !== 1'b1 || fib_out !== 32'd1) begin
      errors++;
      $display("FAIL midrun_third: valid=%b out=%h expected valid=1 out=00000001",
               fib_valid, fib_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (alu_a !== '0 || alu_b !== '0 || fib_out !== '0 || fib_valid !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL midrun_async_reset: a=%h b=%h out=%h valid=%b busy=%b done=%b ovf=%b expected all zero",
               alu_a, alu_b, fib_out, fib_valid, busy, done, ovf);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    hold_out = '0;
    ovf_hold = 1'b0;
    test_sequence("after_reset", 32'd0, 32'd1, 10, 1'b0);
  endtask

  initial begin
    test_reset();
    test_idle_hold();
    test_sequence("basic", 32'd0, 32'd1, 10, 1'b0);
    test_sequence("wrap", 32'hFFFF_FFFF, 32'd1, 4, 1'b0);
    test_idle_hold();
    test_sequence("n0", 32'h55, 32'h66, 0, 1'b0);
    test_sequence("n1", 32'd7, 32'd9, 1, 1'b0);
    test_sequence("ignore_start", 32'd0, 32'd1, 10, 1'b1);
    test_midrun_reset();
    test_sequence("b2b_first", 32'd3, 32'd4, 5, 1'b0);
    test_sequence("b2b_second", 32'h8000_0000, 32'h8000_0000, 6, 1'b0);
    for (int r = 0; r < 8; r++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = (r % 2 == 1) ? $urandom : 32'($urandom_range(0, 100));
      b = (r % 3 == 0) ? $urandom : 32'($urandom_range(0, 100));
      test_sequence("random", a, b, int'($urandom_range(0, 20)), r % 4 == 2);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
